// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with run skipping.
// One scan cycle per run of identical multiplier bits; signed or unsigned
// operands; reports add/subtract/cycle counts for performance analysis.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          is_signed,
    input  logic [WIDTH-1:0]              mtpr,
    input  logic [WIDTH-1:0]              mtpd,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(WIDTH+2)-1:0]    adds,
    output logic [$clog2(WIDTH+2)-1:0]    subs,
    output logic [$clog2(WIDTH+2)-1:0]    cycles,
    output logic [2*WIDTH-1:0]            prod
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] N_SIGNED   = CW'(WIDTH);
    localparam logic [CW-1:0] N_UNSIGNED = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH:0]       b_q, b_d;        // extended multiplier, bit WIDTH used only when unsigned
    logic [2*WIDTH-1:0]   m_q, m_d;        // extended multiplicand
    logic [CW-1:0]        n_q, n_d;        // scan length
    logic [CW-1:0]        pos_q, pos_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        adds_q, adds_d;
    logic [CW-1:0]        subs_q, subs_d;
    logic [CW-1:0]        cycles_q, cycles_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 cur_bit_s;
    logic                 prev_bit_s;
    logic [CW-1:0]        pos_nxt_s;
    logic [2*WIDTH-1:0]   shifted_s;

    // Pick out B[pos] and B[pos-1] (B[-1] = 0) and find the start of the next run.
    always_comb begin
        cur_bit_s  = 1'b0;
        prev_bit_s = 1'b0;
        pos_nxt_s  = n_q;
        for (int i = 0; i <= WIDTH; i++) begin
            if (CW'(i) == pos_q) begin
                cur_bit_s = b_q[i];
            end else if (CW'(i + 1) == pos_q) begin
                prev_bit_s = b_q[i];
            end else begin
                cur_bit_s = cur_bit_s;
            end
        end
        // Walk downward so the lowest qualifying index is the one kept.
        for (int i = WIDTH; i >= 0; i--) begin
            if ((CW'(i) > pos_q) && (CW'(i) < n_q) && (b_q[i] != cur_bit_s)) begin
                pos_nxt_s = CW'(i);
            end else begin
                pos_nxt_s = pos_nxt_s;
            end
        end
        shifted_s = m_q << pos_q;
    end

    // Next-state logic for the controller and datapath registers.
    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        m_d      = m_q;
        n_d      = n_q;
        pos_d    = pos_q;
        prod_d   = prod_q;
        adds_d   = adds_q;
        subs_d   = subs_q;
        cycles_d = cycles_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (is_signed) begin
                        b_d = {mtpr[WIDTH-1], mtpr};
                        m_d = {{WIDTH{mtpd[WIDTH-1]}}, mtpd};
                        n_d = N_SIGNED;
                    end else begin
                        b_d = {1'b0, mtpr};
                        m_d = {{WIDTH{1'b0}}, mtpd};
                        n_d = N_UNSIGNED;
                    end
                    state_d  = ST_SCAN;
                    pos_d    = {CW{1'b0}};
                    prod_d   = {(2*WIDTH){1'b0}};
                    adds_d   = {CW{1'b0}};
                    subs_d   = {CW{1'b0}};
                    cycles_d = {CW{1'b0}};
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SCAN: begin
                // A start pulse here is deliberately ignored.
                if (cur_bit_s && !prev_bit_s) begin
                    prod_d = prod_q - shifted_s;
                    subs_d = subs_q + {{(CW-1){1'b0}}, 1'b1};
                end else if (!cur_bit_s && prev_bit_s) begin
                    prod_d = prod_q + shifted_s;
                    adds_d = adds_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    prod_d = prod_q;
                end
                cycles_d = cycles_q + {{(CW-1){1'b0}}, 1'b1};
                pos_d    = pos_nxt_s;
                if (pos_nxt_s == n_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            b_q      <= {(WIDTH+1){1'b0}};
            m_q      <= {(2*WIDTH){1'b0}};
            n_q      <= {CW{1'b0}};
            pos_q    <= {CW{1'b0}};
            prod_q   <= {(2*WIDTH){1'b0}};
            adds_q   <= {CW{1'b0}};
            subs_q   <= {CW{1'b0}};
            cycles_q <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            m_q      <= m_d;
            n_q      <= n_d;
            pos_q    <= pos_d;
            prod_q   <= prod_d;
            adds_q   <= adds_d;
            subs_q   <= subs_d;
            cycles_q <= cycles_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign adds   = adds_q;
    assign subs   = subs_q;
    assign cycles = cycles_q;
    assign prod   = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed testbench for booth_mul_seq (WIDTH=32) with hand-computed expectations.
module tb_booth_mul_seq;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 2);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  mtpr;
    logic [W-1:0]  mtpd;
    logic          busy;
    logic          done;
    logic [CW-1:0] adds;
    logic [CW-1:0] subs;
    logic [CW-1:0] cycles;
    logic [2*W-1:0] prod;

    int errors = 0;
    int checks = 0;
    int lat;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .mtpr      (mtpr),
        .mtpd      (mtpd),
        .busy      (busy),
        .done      (done),
        .adds      (adds),
        .subs      (subs),
        .cycles    (cycles),
        .prod      (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle; returns at the negedge after the start edge.
    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        mtpr      = a;
        mtpd      = b;
        @(negedge clk);
        start     = 1'b0;
        mtpr      = 32'h0000_0000;
        mtpd      = 32'h0000_0000;
    endtask

    // Count scan edges until done; optionally pulse start at scan cycle pulse_at.
    task automatic wait_done(input int pulse_at, output int l);
        l = 0;
        while (!done && l < 200) begin
            if (l == pulse_at) begin
                start     = 1'b1;
                is_signed = 1'b0;
                mtpr      = 32'h0000_0000;
                mtpd      = 32'h0000_0009;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            l++;
        end
        start = 1'b0;
        chk("timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic chk_res(input string tag, input logic [63:0] p, input int a, input int s,
                           input int c, input int l);
        chk({tag, "_prod"}, prod, p);
        chk({tag, "_adds"}, 64'(adds), 64'(a));
        chk({tag, "_subs"}, 64'(subs), 64'(s));
        chk({tag, "_cycles"}, 64'(cycles), 64'(c));
        chk({tag, "_lat"}, 64'(lat), 64'(l));
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        mtpr      = 32'h0000_0000;
        mtpd      = 32'h0000_0000;
        repeat (2) @(negedge clk);
        chk("rst_prod", prod, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        rst_n = 1'b1;

        // 3 * 5 signed: subtract at bit 0, add at bit 2.
        launch(1'b1, 32'd3, 32'd5);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_done_low", {63'd0, done}, 64'd0);
        wait_done(-1, lat);
        chk_res("t1", 64'd15, 1, 1, 2, 2);

        // -1 * -1 signed: a single run of ones.
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(-1, lat);
        chk_res("t2", 64'd1, 0, 1, 1, 1);

        // Unsigned max * max: extra zero bit closes the run.
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(-1, lat);
        chk_res("t3", 64'hFFFF_FFFE_0000_0001, 1, 1, 2, 2);

        // Signed most-negative squared.
        launch(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done(-1, lat);
        chk_res("t4", 64'h4000_0000_0000_0000, 0, 1, 2, 2);

        // Alternating bits: worst case, with an ignored start pulse mid-scan.
        launch(1'b1, 32'h5555_5555, 32'd1);
        wait_done(10, lat);
        chk_res("t5", 64'h0000_0000_5555_5555, 16, 16, 32, 32);

        // Reset in the middle of a scan clears every output at once.
        launch(1'b1, 32'h5555_5555, 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_prod", prod, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_adds", 64'(adds), 64'd0);
        chk("rst_mid_subs", 64'(subs), 64'd0);
        chk("rst_mid_cycles", 64'(cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero multiplier: one no-op scan cycle.
        launch(1'b1, 32'd0, 32'd7);
        wait_done(-1, lat);
        chk_res("t6", 64'd0, 0, 0, 1, 1);

        // Back-to-back restart straight from DONE.
        launch(1'b1, 32'd2, 32'd7);
        chk("t7_done_drop", {63'd0, done}, 64'd0);
        chk("t7_busy", {63'd0, busy}, 64'd1);
        wait_done(-1, lat);
        chk_res("t7", 64'd14, 1, 1, 3, 3);

        // Results hold in DONE while start stays low.
        repeat (3) @(negedge clk);
        chk("t7_hold_prod", prod, 64'd14);
        chk("t7_hold_done", {63'd0, done}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
